// File: rtl/cache_pkg.sv
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared constants, FSM state encoding and address-field
//                helpers for the 2-way set-associative L1 data cache.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    // Address geometry: 32-bit address = {tag[20:0], index[5:0], offset[4:0]}
    localparam int unsigned c_ADDR_W   = 32;
    localparam int unsigned c_TAG_W    = 21;
    localparam int unsigned c_INDEX_W  = 6;
    localparam int unsigned c_OFFSET_W = 5;

    // Controller state encoding
    localparam int unsigned c_STATE_W     = 3;
    localparam logic [2:0]  c_ST_IDLE      = 3'd0;
    localparam logic [2:0]  c_ST_COMPARE   = 3'd1;
    localparam logic [2:0]  c_ST_WRITEBACK = 3'd2;
    localparam logic [2:0]  c_ST_REFILL    = 3'd3;
    localparam logic [2:0]  c_ST_FILL      = 3'd4;
    localparam logic [2:0]  c_ST_LOOKUP    = 3'd5;

    function automatic logic [c_TAG_W-1:0] get_tag(input logic [c_ADDR_W-1:0] a);
        return a[c_ADDR_W-1 -: c_TAG_W];
    endfunction

    function automatic logic [c_INDEX_W-1:0] get_index(input logic [c_ADDR_W-1:0] a);
        return a[c_OFFSET_W +: c_INDEX_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_lru.sv
// ============================================================================
//  Module      : cache_lru
//  Description : Per-set LRU bit store for a 2-way cache. One bit per set
//                holding the least-recently-used way (0=way1, 1=way2).
//                Combinational read port, single update port, synchronous
//                clear of every set on rst.
//  Ports       : clk, rst            - clock, sync active-high clear
//                i_rd_index/o_rd_lru - read port
//                i_upd_en/i_upd_index/i_upd_val - write port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_lru #(
    parameter int unsigned INDEX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_lru,
    input  logic               i_upd_en,
    input  logic [INDEX_W-1:0] i_upd_index,
    input  logic               i_upd_val
);

    logic [(2**INDEX_W)-1:0] r_lru;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lru <= '0;
        end else if (i_upd_en) begin
            r_lru[i_upd_index] <= i_upd_val;
        end
    end

    assign o_rd_lru = r_lru[i_rd_index];

endmodule

`default_nettype wire

// File: rtl/l1_cache_ctrl.sv
// ============================================================================
//  Module      : l1_cache_ctrl
//  Description : Sequencing controller for a 2-way set-associative L1 data
//                cache. Accepts level load/store requests, runs the tag
//                compare, selects a victim (invalid-first, then LRU) and
//                sequences dirty write-back and refill against L2.
//  Ports       : ld/st/addr         - core request (held until done)
//                tag*/valid*/dirty* - tag array read data (1-cycle latency)
//                index              - tag/data array index
//                hit/miss/load_ready/done - request status pulses
//                write_l1/fill/set_dirty/way_sel - L1 array write control
//                read_l2/write_l2/l2_addr/l2_ack - L2 handshake
//                busy               - controller not idle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = c_ADDR_W,
    parameter int unsigned TAG_W    = c_TAG_W,
    parameter int unsigned INDEX_W  = c_INDEX_W,
    parameter int unsigned OFFSET_W = c_OFFSET_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic               st,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [TAG_W-1:0]   tag1_loaded,
    input  logic [TAG_W-1:0]   tag2_loaded,
    input  logic               valid1,
    input  logic               valid2,
    input  logic               dirty1,
    input  logic               dirty2,
    input  logic               l2_ack,
    output logic [INDEX_W-1:0] index,
    output logic               hit,
    output logic               miss,
    output logic               load_ready,
    output logic               done,
    output logic               write_l1,
    output logic               fill,
    output logic               set_dirty,
    output logic               way_sel,
    output logic               read_l2,
    output logic               write_l2,
    output logic [ADDR_W-1:0]  l2_addr,
    output logic               busy
);

    localparam int unsigned c_LINE_W = ADDR_W - OFFSET_W;

    logic [c_STATE_W-1:0] r_state, w_state_nxt;
    logic [c_LINE_W-1:0]  r_line, w_line_nxt;        // latched tag+index
    logic                 r_is_load, w_is_load_nxt;
    logic                 r_victim, w_victim_nxt;
    logic [TAG_W-1:0]     r_victim_tag, w_victim_tag_nxt;

    logic [TAG_W-1:0]     w_req_tag;
    logic [INDEX_W-1:0]   w_req_index;
    logic                 w_hit1;
    logic                 w_hit2;
    logic                 w_hit_any;
    logic                 w_lru_bit;
    logic                 w_victim_cmp;
    logic                 w_victim_dirty;
    logic                 w_lru_upd_en;
    logic                 w_unused_offset;

    // Line offset never reaches the controller's outputs.
    assign w_unused_offset = ^addr[OFFSET_W-1:0];

    assign w_req_tag   = r_line[c_LINE_W-1 -: TAG_W];
    assign w_req_index = r_line[INDEX_W-1:0];

    assign w_hit1    = valid1 && (tag1_loaded == w_req_tag);
    assign w_hit2    = valid2 && (tag2_loaded == w_req_tag);
    assign w_hit_any = w_hit1 || w_hit2;

    // Invalid ways are filled first; only a fully valid set consults LRU.
    assign w_victim_cmp   = !valid1 ? 1'b0 : (!valid2 ? 1'b1 : w_lru_bit);
    assign w_victim_dirty = w_victim_cmp ? (valid2 && dirty2) : (valid1 && dirty1);

    // The LRU bit names the way NOT just used; way1 wins a double hit.
    assign w_lru_upd_en = (r_state == c_ST_COMPARE) && w_hit_any;

    cache_lru #(
        .INDEX_W (INDEX_W)
    ) u_lru (
        .clk         (clk),
        .rst         (rst),
        .i_rd_index  (w_req_index),
        .o_rd_lru    (w_lru_bit),
        .i_upd_en    (w_lru_upd_en),
        .i_upd_index (w_req_index),
        .i_upd_val   (w_hit1)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_line_nxt       = r_line;
        w_is_load_nxt    = r_is_load;
        w_victim_nxt     = r_victim;
        w_victim_tag_nxt = r_victim_tag;
        index            = w_req_index;
        hit              = 1'b0;
        miss             = 1'b0;
        load_ready       = 1'b0;
        done             = 1'b0;
        write_l1         = 1'b0;
        fill             = 1'b0;
        set_dirty        = 1'b0;
        way_sel          = 1'b0;
        read_l2          = 1'b0;
        write_l2         = 1'b0;
        l2_addr          = '0;

        case (r_state)
            c_ST_IDLE: begin
                index = addr[OFFSET_W +: INDEX_W];
                if (ld || st) begin
                    w_line_nxt    = addr[ADDR_W-1:OFFSET_W];
                    w_is_load_nxt = ld;   // load wins when both are raised
                    w_state_nxt   = c_ST_COMPARE;
                end
            end
            c_ST_COMPARE: begin
                if (w_hit_any) begin
                    hit         = 1'b1;
                    done        = 1'b1;
                    load_ready  = r_is_load;
                    write_l1    = !r_is_load;
                    set_dirty   = !r_is_load;
                    way_sel     = !r_is_load && !w_hit1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    miss             = 1'b1;
                    w_victim_nxt     = w_victim_cmp;
                    w_victim_tag_nxt = w_victim_cmp ? tag2_loaded : tag1_loaded;
                    w_state_nxt      = w_victim_dirty ? c_ST_WRITEBACK : c_ST_REFILL;
                end
            end
            c_ST_WRITEBACK: begin
                write_l2 = 1'b1;
                l2_addr  = {r_victim_tag, w_req_index, {OFFSET_W{1'b0}}};
                if (l2_ack) begin
                    w_state_nxt = c_ST_REFILL;
                end
            end
            c_ST_REFILL: begin
                read_l2 = 1'b1;
                l2_addr = {w_req_tag, w_req_index, {OFFSET_W{1'b0}}};
                if (l2_ack) begin
                    w_state_nxt = c_ST_FILL;
                end
            end
            c_ST_FILL: begin
                write_l1    = 1'b1;
                fill        = 1'b1;
                way_sel     = r_victim;
                w_state_nxt = c_ST_LOOKUP;
            end
            c_ST_LOOKUP: begin
                // Tag arrays need one cycle to return the freshly filled way.
                w_state_nxt = c_ST_COMPARE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        busy = (r_state != c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_line       <= '0;
            r_is_load    <= 1'b0;
            r_victim     <= 1'b0;
            r_victim_tag <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_line       <= w_line_nxt;
            r_is_load    <= w_is_load_nxt;
            r_victim     <= w_victim_nxt;
            r_victim_tag <= w_victim_tag_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l1_cache_ctrl.sv
// ============================================================================
//  Module      : tb_l1_cache_ctrl
//  Description : Self-checking bench for l1_cache_ctrl. Models the tag arrays
//                (1-cycle synchronous read) and an L2 responder; expected
//                per-cycle strobe activity is queued with each request and
//                compared as the controller produces it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_cache_ctrl;

    // Strobe bit positions within an observed event word
    localparam logic [9:0] S_HIT  = 10'b10_0000_0000;
    localparam logic [9:0] S_MISS = 10'b01_0000_0000;
    localparam logic [9:0] S_LR   = 10'b00_1000_0000;
    localparam logic [9:0] S_DONE = 10'b00_0100_0000;
    localparam logic [9:0] S_WL1  = 10'b00_0010_0000;
    localparam logic [9:0] S_FILL = 10'b00_0001_0000;
    localparam logic [9:0] S_SD   = 10'b00_0000_1000;
    localparam logic [9:0] S_WS   = 10'b00_0000_0100;
    localparam logic [9:0] S_RL2  = 10'b00_0000_0010;
    localparam logic [9:0] S_WL2  = 10'b00_0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld = 1'b0;
    logic        st = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [20:0] tag1_loaded = '0;
    logic [20:0] tag2_loaded = '0;
    logic        valid1 = 1'b0, valid2 = 1'b0, dirty1 = 1'b0, dirty2 = 1'b0;
    logic        l2_ack = 1'b0;
    logic [5:0]  index;
    logic        hit, miss, load_ready, done, write_l1, fill, set_dirty, way_sel;
    logic        read_l2, write_l2, busy;
    logic [31:0] l2_addr;

    l1_cache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ld          (ld),
        .st          (st),
        .addr        (addr),
        .tag1_loaded (tag1_loaded),
        .tag2_loaded (tag2_loaded),
        .valid1      (valid1),
        .valid2      (valid2),
        .dirty1      (dirty1),
        .dirty2      (dirty2),
        .l2_ack      (l2_ack),
        .index       (index),
        .hit         (hit),
        .miss        (miss),
        .load_ready  (load_ready),
        .done        (done),
        .write_l1    (write_l1),
        .fill        (fill),
        .set_dirty   (set_dirty),
        .way_sel     (way_sel),
        .read_l2     (read_l2),
        .write_l2    (write_l2),
        .l2_addr     (l2_addr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned t0  = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] cur_addr = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [63:0] ev(input int rel, input logic [9:0] s, input logic [31:0] a);
        return {14'b0, 8'(rel), s, a};
    endfunction

    // ---------------- tag array model (1-cycle synchronous read) -------------
    bit [20:0]   m_tag1[64], m_tag2[64];
    bit          m_v1[64], m_v2[64], m_d1[64], m_d2[64];
    logic        pl_en = 1'b0, pl_way = 1'b0, pl_v = 1'b0, pl_d = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [20:0] pl_tag = '0;

    always @(posedge clk) begin
        tag1_loaded <= m_tag1[index];
        tag2_loaded <= m_tag2[index];
        valid1      <= m_v1[index];
        valid2      <= m_v2[index];
        dirty1      <= m_d1[index];
        dirty2      <= m_d2[index];
        if (pl_en) begin
            if (!pl_way) begin
                m_tag1[pl_idx] <= pl_tag; m_v1[pl_idx] <= pl_v; m_d1[pl_idx] <= pl_d;
            end else begin
                m_tag2[pl_idx] <= pl_tag; m_v2[pl_idx] <= pl_v; m_d2[pl_idx] <= pl_d;
            end
        end else if (write_l1) begin
            if (fill) begin
                if (!way_sel) begin
                    m_tag1[index] <= cur_addr[31:11]; m_v1[index] <= 1'b1; m_d1[index] <= 1'b0;
                end else begin
                    m_tag2[index] <= cur_addr[31:11]; m_v2[index] <= 1'b1; m_d2[index] <= 1'b0;
                end
            end else if (set_dirty) begin
                if (!way_sel) m_d1[index] <= 1'b1;
                else          m_d2[index] <= 1'b1;
            end
        end
    end

    // ---------------- L2 responder -------------------------------------------
    int ack_delay = 1;
    int ack_cnt   = 0;
    bit ack_auto  = 1'b1;
    bit ack_force = 1'b0;

    always @(negedge clk) begin
        if (ack_auto) begin
            if (read_l2 || write_l2) begin
                ack_cnt = l2_ack ? 1 : ack_cnt + 1;
                l2_ack  = (ack_cnt >= ack_delay);
            end else begin
                ack_cnt = 0;
                l2_ack  = 1'b0;
            end
        end else begin
            l2_ack = ack_force;
        end
    end

    // ---------------- output monitor -----------------------------------------
    logic [9:0]  mon_s;
    logic [63:0] mon_obs;

    always @(negedge clk) begin
        mon_s = {hit, miss, load_ready, done, write_l1, fill & write_l1,
                 set_dirty & write_l1, way_sel & write_l1, read_l2, write_l2};
        if (|mon_s) begin
            mon_obs = ev(int'(cyc - t0), mon_s, (read_l2 || write_l2) ? l2_addr : 32'h0);
            if (exp_q.size() == 0) check("extra_event", mon_obs, 64'h0);
            else                   check("event", mon_obs, exp_q.pop_front());
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic preload(input bit way, input logic [5:0] idx, input logic [20:0] tg,
                           input bit v, input bit d);
        pl_way = way; pl_idx = idx; pl_tag = tg; pl_v = v; pl_d = d; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Caller is #1 after a posedge; that cycle is request cycle 0.
    task automatic do_req(input bit l, input bit s, input logic [31:0] a,
                          input int dly, input int budget);
        bit seen;
        seen      = 1'b0;
        ack_delay = dly;
        cur_addr  = a;
        t0        = cyc;
        ld = l; st = s; addr = a;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_timeout", {63'b0, seen}, 64'h1);
        @(posedge clk); #1;
        ld = 1'b0; st = 1'b0;
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        check("idle_after_done", {63'b0, busy}, 64'h0);
    endtask

    initial begin
        // Reset held 2 cycles with a load pending: nothing must be accepted.
        ld = 1'b1; addr = 32'h0000_1240;
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", {58'b0, busy, hit, miss, read_l2, write_l2, write_l1}, 64'h0);
        check("rst_index", {58'b0, index}, 64'h12);
        sync();
        rst = 1'b0; ld = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {63'b0, busy}, 64'h0);

        // Load hit in way1 (tag 0x2, index 0x12); lru[0x12] -> 1
        sync();
        preload(1'b0, 6'h12, 21'h2, 1'b1, 1'b0);
        exp_q.push_back(ev(1, S_HIT | S_LR | S_DONE, 32'h0));
        do_req(1'b1, 1'b0, 32'h0000_1240, 1, 20);

        // Clean miss, way1 invalid: refill into way1, done at cycle 5
        sync();
        preload(1'b0, 6'h12, 21'h2, 1'b0, 1'b0);
        exp_q.push_back(ev(1, S_MISS, 32'h0));
        exp_q.push_back(ev(2, S_RL2, 32'h0000_1240));
        exp_q.push_back(ev(3, S_WL1 | S_FILL, 32'h0));
        exp_q.push_back(ev(5, S_HIT | S_LR | S_DONE, 32'h0));
        do_req(1'b1, 1'b0, 32'h0000_1240, 1, 20);

        // Dirty miss, lru=1 -> victim way2 (tag 0x7 dirty); ack after 3 cycles
        sync();
        preload(1'b0, 6'h12, 21'h5, 1'b1, 1'b0);
        preload(1'b1, 6'h12, 21'h7, 1'b1, 1'b1);
        exp_q.push_back(ev(1, S_MISS, 32'h0));
        for (int c = 2; c <= 4; c++) exp_q.push_back(ev(c, S_WL2, 32'h0000_3A40));
        for (int c = 5; c <= 7; c++) exp_q.push_back(ev(c, S_RL2, 32'h0000_1240));
        exp_q.push_back(ev(8, S_WL1 | S_FILL | S_WS, 32'h0));
        exp_q.push_back(ev(10, S_HIT | S_LR | S_DONE, 32'h0));
        do_req(1'b1, 1'b0, 32'h0000_1240, 3, 30);

        // Load hit way1 (tag 0x5) -> lru=1, then store hit way2 -> lru=0
        sync();
        exp_q.push_back(ev(1, S_HIT | S_LR | S_DONE, 32'h0));
        do_req(1'b1, 1'b0, 32'h0000_2A40, 1, 20);
        sync();
        exp_q.push_back(ev(1, S_HIT | S_WL1 | S_SD | S_WS | S_DONE, 32'h0));
        do_req(1'b0, 1'b1, 32'h0000_1240, 1, 20);

        // Both ways valid, lru=0 -> clean way1 victim (way2 is now dirty)
        sync();
        exp_q.push_back(ev(1, S_MISS, 32'h0));
        exp_q.push_back(ev(2, S_RL2, 32'h0000_4A40));
        exp_q.push_back(ev(3, S_WL1 | S_FILL, 32'h0));
        exp_q.push_back(ev(5, S_HIT | S_LR | S_DONE, 32'h0));
        do_req(1'b1, 1'b0, 32'h0000_4A40, 1, 20);

        // ld and st together: served as a load
        sync();
        exp_q.push_back(ev(1, S_HIT | S_LR | S_DONE, 32'h0));
        do_req(1'b1, 1'b1, 32'h0000_4A40, 1, 20);

        // Reset while REFILL waits on L2; a late ack must be ignored
        sync();
        ack_auto = 1'b0;
        exp_q.push_back(ev(1, S_MISS, 32'h0));
        exp_q.push_back(ev(2, S_RL2, 32'h0000_1260));
        exp_q.push_back(ev(3, S_RL2, 32'h0000_1260));
        cur_addr = 32'h0000_1260; t0 = cyc; ld = 1'b1; addr = 32'h0000_1260;
        repeat (3) sync();
        rst = 1'b1; ld = 1'b0;
        sync();
        check("rst_mid_read_l2", {62'b0, read_l2, busy}, 64'h0);
        rst = 1'b0; ack_force = 1'b1;
        sync();
        ack_force = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("ack_ignored_busy", {63'b0, busy}, 64'h0);
        end
        check("rst_queue_drained", 64'(exp_q.size()), 64'h0);
        ack_auto = 1'b1;

        // LRU cleared by reset: lru[0x12]=0 picks clean way1, not dirty way2
        sync();
        exp_q.push_back(ev(1, S_MISS, 32'h0));
        exp_q.push_back(ev(2, S_RL2, 32'h0000_1A40));
        exp_q.push_back(ev(3, S_WL1 | S_FILL, 32'h0));
        exp_q.push_back(ev(5, S_HIT | S_LR | S_DONE, 32'h0));
        do_req(1'b1, 1'b0, 32'h0000_1A40, 1, 20);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
